// File: rtl/l2_types_pkg.sv
// Shared types for the L2 read-response path: line width, line type and FSM state encoding.
package l2_types_pkg;

    localparam int LINE_W = 256;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIT_RESP,
        ST_FETCH,
        ST_FILL,
        ST_MISS_RESP
    } state_t;

endpackage

// File: rtl/l2_line_assembler.sv
// Collects BEATS memory beats into one cache line; beat k lands in slot k.
module l2_line_assembler
    import l2_types_pkg::*;
#(
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_valid,
    input  logic [BEAT_W-1:0] beat_data,
    output line_t             line,
    output logic              done
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (beat_valid) begin
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

    // One register per slot so each slice of the line has a single driver.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slot
            logic [BEAT_W-1:0] slot_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (beat_valid && (cnt_reg == CNT_W'(gi))) begin
                    slot_reg <= beat_data;
                end
            end

            assign line[gi*BEAT_W +: BEAT_W] = slot_reg;
        end
    endgenerate

    assign done = beat_valid && (cnt_reg == LAST);

endmodule

// File: rtl/l2_read_resp.sv
// L2 read-response controller: serves hits from the data array, misses by a
// burst fetch from physical memory followed by a line fill and response.
module l2_read_resp
    import l2_types_pkg::*;
#(
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l1_read,
    input  logic [31:0]       l1_address,
    output line_t             l1_rdata,
    output logic              l1_resp,
    input  logic              hit1,
    input  logic              hit2,
    input  line_t             data1,
    input  line_t             data2,
    input  logic              lru,
    output logic              pmem_read,
    output logic [31:0]       pmem_address,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              fill_we,
    output logic              fill_way,
    output line_t             fill_data
);

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic        lru_reg;
    line_t       hit_data_reg;
    line_t       line;
    logic        beat_valid;
    logic        beat_done;
    logic        accept;

    assign accept     = (state_reg == ST_IDLE) && l1_read;
    assign beat_valid = (state_reg == ST_FETCH) && pmem_resp;

    l2_line_assembler #(
        .BEAT_W(BEAT_W)
    ) u_assembler (
        .clk       (clk),
        .rst       (rst),
        .beat_valid(beat_valid),
        .beat_data (pmem_rdata),
        .line      (line),
        .done      (beat_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request context is captured once on leaving IDLE; way 1 wins a dual hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg     <= '0;
            lru_reg      <= 1'b0;
            hit_data_reg <= '0;
        end else if (accept) begin
            addr_reg <= l1_address & 32'hFFFF_FFE0;
            lru_reg  <= lru;
            if (hit1) begin
                hit_data_reg <= data1;
            end else if (hit2) begin
                hit_data_reg <= data2;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        l1_resp    = 1'b0;
        l1_rdata   = '0;
        pmem_read  = 1'b0;
        fill_we    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (l1_read) begin
                    state_next = (hit1 || hit2) ? ST_HIT_RESP : ST_FETCH;
                end
            end
            ST_HIT_RESP: begin
                l1_resp    = 1'b1;
                l1_rdata   = hit_data_reg;
                state_next = ST_IDLE;
            end
            ST_FETCH: begin
                pmem_read = 1'b1;
                if (beat_done) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                fill_we    = 1'b1;
                state_next = ST_MISS_RESP;
            end
            ST_MISS_RESP: begin
                l1_resp    = 1'b1;
                l1_rdata   = line;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign pmem_address = addr_reg;
    assign fill_way     = lru_reg;
    assign fill_data    = line;

endmodule

// File: tb/tb_l2_read_resp.sv
// Directed bench for l2_read_resp: table of hit vectors plus miss/reset/stray-beat sequences.
module tb_l2_read_resp;

    logic         clk = 1'b0;
    logic         rst;
    logic         l1_read;
    logic [31:0]  l1_address;
    logic [255:0] l1_rdata;
    logic         l1_resp;
    logic         hit1, hit2;
    logic [255:0] data1, data2;
    logic         lru;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;
    logic         fill_we;
    logic         fill_way;
    logic [255:0] fill_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l2_read_resp #(.BEAT_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .l1_read     (l1_read),
        .l1_address  (l1_address),
        .l1_rdata    (l1_rdata),
        .l1_resp     (l1_resp),
        .hit1        (hit1),
        .hit2        (hit2),
        .data1       (data1),
        .data2       (data2),
        .lru         (lru),
        .pmem_read   (pmem_read),
        .pmem_address(pmem_address),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp),
        .fill_we     (fill_we),
        .fill_way    (fill_way),
        .fill_data   (fill_data)
    );

    typedef struct {
        string        name;
        logic         h1;
        logic         h2;
        logic [255:0] d1;
        logic [255:0] d2;
        logic [31:0]  addr;
        logic [255:0] exp;
    } hit_vec_t;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_hit(input hit_vec_t v);
        @(negedge clk);
        l1_read = 1'b1; l1_address = v.addr;
        hit1 = v.h1; hit2 = v.h2; data1 = v.d1; data2 = v.d2;
        @(negedge clk);
        chk({v.name, " resp"},      {255'd0, l1_resp}, 256'd1);
        chk({v.name, " rdata"},     l1_rdata, v.exp);
        chk({v.name, " pmem_read"}, {255'd0, pmem_read}, 256'd0);
        l1_read = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
        data1 = '0; data2 = '0;
        @(negedge clk);
        chk({v.name, " resp drop"}, {255'd0, l1_resp}, 256'd0);
        chk({v.name, " fill_we"},   {255'd0, fill_we}, 256'd0);
        $display("hit  %-10s addr=%h rdata[63:0]=%h", v.name, v.addr, v.exp[63:0]);
    endtask

    task automatic do_miss(input string nm, input logic [31:0] a, input logic lv,
                           input logic [255:0] ln, input int gap);
        @(negedge clk);
        l1_read = 1'b1; l1_address = a; lru = lv; hit1 = 1'b0; hit2 = 1'b0;
        @(negedge clk);
        l1_read = 1'b0; lru = ~lv;
        chk({nm, " pmem_read"}, {255'd0, pmem_read}, 256'd1);
        chk({nm, " pmem_addr"}, {224'd0, pmem_address}, {224'd0, a & 32'hFFFF_FFE0});
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                pmem_resp = 1'b0; pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                @(negedge clk);
                chk({nm, " gap pmem_read"}, {255'd0, pmem_read}, 256'd1);
            end
            pmem_resp = 1'b1; pmem_rdata = ln[k*64 +: 64];
            @(negedge clk);
            pmem_resp = 1'b0;
            if (k < 3) chk({nm, " beat pmem_read"}, {255'd0, pmem_read}, 256'd1);
        end
        chk({nm, " fill_we"},       {255'd0, fill_we}, 256'd1);
        chk({nm, " fill_way"},      {255'd0, fill_way}, {255'd0, lv});
        chk({nm, " fill_data"},     fill_data, ln);
        chk({nm, " fill pmem_rd"},  {255'd0, pmem_read}, 256'd0);
        chk({nm, " fill resp"},     {255'd0, l1_resp}, 256'd0);
        @(negedge clk);
        chk({nm, " resp"},          {255'd0, l1_resp}, 256'd1);
        chk({nm, " rdata"},         l1_rdata, ln);
        chk({nm, " resp fill_we"},  {255'd0, fill_we}, 256'd0);
        @(negedge clk);
        chk({nm, " resp drop"},     {255'd0, l1_resp}, 256'd0);
        $display("miss %-10s addr=%h lru=%0d gap=%0d", nm, a, lv, gap);
    endtask

    logic [255:0] line_a, line_b, line_c;
    hit_vec_t     hv [4];

    initial begin
        hv[0] = '{"way1",  1'b1, 1'b0, {32{8'hA5}}, {32{8'h5A}}, 32'h0000_0040, {32{8'hA5}}};
        hv[1] = '{"dual",  1'b1, 1'b1, 256'd1,      256'd2,      32'h0000_0080, 256'd1};
        hv[2] = '{"way2",  1'b0, 1'b1, 256'd7,      {8{32'hC0DE_F00D}}, 32'hFFFF_FFFF, {8{32'hC0DE_F00D}}};
        hv[3] = '{"way1b", 1'b1, 1'b0, {4{64'h0123_4567_89AB_CDEF}}, 256'd0, 32'h1000_0000,
                  {4{64'h0123_4567_89AB_CDEF}}};
        line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line_b = {64'hDDDD_0004_DDDD_0004, 64'hCCCC_0003_CCCC_0003,
                  64'hBBBB_0002_BBBB_0002, 64'hAAAA_0001_AAAA_0001};
        line_c = {64'h8000_0000_0000_0008, 64'h0700_0000_0000_0070,
                  64'h0060_0000_0000_0600, 64'h0005_0000_0000_5000};

        rst = 1'b1; l1_read = 1'b0; l1_address = '0; hit1 = 1'b0; hit2 = 1'b0;
        data1 = '0; data2 = '0; lru = 1'b0; pmem_rdata = '0; pmem_resp = 1'b0;
        @(negedge clk);
        chk("rst resp",      {255'd0, l1_resp}, 256'd0);
        chk("rst pmem_read", {255'd0, pmem_read}, 256'd0);
        chk("rst fill_we",   {255'd0, fill_we}, 256'd0);
        chk("rst rdata",     l1_rdata, 256'd0);
        chk("rst pmem_addr", {224'd0, pmem_address}, 256'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) do_hit(hv[i]);

        do_miss("miss", 32'h0000_1234, 1'b1, line_a, 0);
        do_miss("gap3", 32'h0000_1234, 1'b0, line_a, 3);

        // Reset after two beats of a burst, then the leftover beats arrive.
        @(negedge clk);
        l1_read = 1'b1; l1_address = 32'h0000_5678; lru = 1'b1;
        @(negedge clk);
        l1_read = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pmem_resp = 1'b1; pmem_rdata = line_c[k*64 +: 64];
            @(negedge clk);
        end
        pmem_resp = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst resp",      {255'd0, l1_resp}, 256'd0);
        chk("midrst pmem_read", {255'd0, pmem_read}, 256'd0);
        chk("midrst fill_we",   {255'd0, fill_we}, 256'd0);
        chk("midrst rdata",     l1_rdata, 256'd0);
        chk("midrst pmem_addr", {224'd0, pmem_address}, 256'd0);
        chk("midrst fill_data", fill_data, 256'd0);
        $display("rst  mid-burst after 2 beats");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 2; k < 4; k++) begin
            pmem_resp = 1'b1; pmem_rdata = line_c[k*64 +: 64];
            @(negedge clk);
            chk("stray pmem_read", {255'd0, pmem_read}, 256'd0);
            chk("stray resp",      {255'd0, l1_resp}, 256'd0);
        end
        pmem_resp = 1'b0;
        do_miss("postrst", 32'h0000_9ABC, 1'b0, line_b, 0);

        // Stray beats in IDLE must not disturb a following hit or the beat counter.
        pmem_resp = 1'b1; pmem_rdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        pmem_resp = 1'b0;
        do_hit(hv[0]);
        do_miss("stray", 32'hABCD_EF1F, 1'b1, line_c, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/l2_read_resp.md
L2_READ_RESP -- requirements
Module: l2_read_resp

Interface
REQ-001 Parameter: BEAT_W, 64, physical-memory beat width in bits; line width fixed at 256, so BEATS = 256/BEAT_W = 4.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 l1_read  in  1  L1 read request; held high by requester until l1_resp.
REQ-005 l1_address  in  32  byte address of requested line; only [31:5] significant.
REQ-006 l1_rdata  out  256  returned line; valid only while l1_resp=1.
REQ-007 l1_resp  out  1  one-cycle completion pulse to L1.
REQ-008 hit1, hit2  in  1 each  tag-compare hit for way 1 / way 2 on l1_address.
REQ-009 data1, data2  in  256 each  data-array read output of way 1 / way 2.
REQ-010 lru  in  1  victim way for fill (0 = way 1, 1 = way 2).
REQ-011 pmem_read  out  1  burst read request to physical memory.
REQ-012 pmem_address  out  32  line-aligned burst address.
REQ-013 pmem_rdata  in  BEAT_W  burst data beat; valid when pmem_resp=1.
REQ-014 pmem_resp  in  1  one pulse per beat, BEATS pulses per burst.
REQ-015 fill_we  out  1  one-cycle write strobe into the data array.
REQ-016 fill_way  out  1  way selected for fill, equal to latched lru.
REQ-017 fill_data  out  256  assembled line written on fill_we.

Function
REQ-018 FSM states: IDLE, HIT_RESP, FETCH, FILL, MISS_RESP.
REQ-019 IDLE: l1_read=1 and (hit1|hit2) -> HIT_RESP; l1_read=1 and no hit -> FETCH; else stay.
REQ-020 IDLE->any transition latches line address {l1_address[31:5],5'b0} and lru.
REQ-021 IDLE->HIT_RESP latches the hitting way's data; way 1 wins when hit1 and hit2 are both 1.
REQ-022 HIT_RESP: l1_resp=1 and l1_rdata = latched hit data for exactly one cycle, then IDLE; hit latency = 1 cycle after request.
REQ-023 FETCH: pmem_read=1 and pmem_address = latched line address every cycle until the final beat.
REQ-024 Each pmem_resp in FETCH stores pmem_rdata into line slot [k*BEAT_W +: BEAT_W] (beat k=0 at bits 63:0), then increments the 2-bit beat counter.
REQ-025 pmem_resp with counter=3 -> FILL, counter wraps to 0; pmem_read is 0 in the following cycle.
REQ-026 pmem_resp outside FETCH is ignored (no buffer update, no counter change).
REQ-027 FILL: fill_we=1, fill_way = latched lru, fill_data = assembled line, one cycle, then MISS_RESP.
REQ-028 MISS_RESP: l1_resp=1, l1_rdata = assembled line, one cycle, then IDLE.
REQ-029 fill_we=0 in every state except FILL; l1_resp=0 except in HIT_RESP and MISS_RESP.
REQ-030 l1_read, hit and address inputs are ignored outside IDLE; back-to-back requests take 1 IDLE cycle minimum.
REQ-031 fill_data and l1_rdata are driven from registers, with no combinational path from pmem_rdata or data1/data2.

Reset
REQ-032 rst=1 immediately forces IDLE, beat counter 0, and line buffer, latched address and latched lru to 0.
REQ-033 During reset: l1_resp=0, pmem_read=0, fill_we=0, l1_rdata=0, pmem_address=0.
REQ-034 Reset mid-burst abandons the burst; remaining pmem_resp beats after release are ignored per REQ-026.

Structure
REQ-035 Shared package l2_types_pkg holds LINE_W=256, the state enum type and the line typedef.
REQ-036 One sub-module, l2_line_assembler (beat counter plus 256-bit shift/slot buffer with done flag), is instantiated inside; the FSM stays in the top.

Verification
REQ-037 Way-1 hit: l1_read=1, hit1=1, data1=256'hA5.. -> l1_resp pulse next cycle, l1_rdata=256'hA5.., pmem_read never 1.
REQ-038 Dual hit: hit1=hit2=1, data1=1, data2=2 -> l1_rdata=1.
REQ-039 Miss: address 0x0000_1234, lru=1, beats 0x11..,0x22..,0x33..,0x44.. -> pmem_address=0x0000_1220, fill_we one cycle with fill_way=1, fill_data={44..,33..,22..,11..}, l1_resp next cycle.
REQ-040 Beat gaps: pmem_resp with 3 idle cycles between beats -> identical line, pmem_read held continuously.
REQ-041 Reset after beat 2 -> all outputs 0, IDLE; a fresh miss returns only the new burst's data.
REQ-042 Stray pmem_resp in IDLE, followed by a hit -> hit data returned unchanged, counter still 0.
